// File: rtl/ew_pipeline_register.sv
// Execute-to-writeback pipeline register with hold, bubble and flush
// handling, plus the retired-instruction (instret) counter.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   flush_w          squash the E instruction entering W
//   hold_w           W keeps its contents (data memory not ready)
//   bubble_e         E holds no valid instruction
//   *_e              E-stage instruction, PC, ALU result, store data, control
//   *_w              registered W-stage copies of the E-stage fields
//   valid_w          W holds a real instruction
//   instret          count of retired instructions (wraps)
module ew_pipeline_register #(
    parameter int unsigned    XLEN     = 32,
    parameter int unsigned    CNT_W    = 64,
    parameter logic [31:0]    NOP_INSN = 32'h00000013
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_w,
    input  logic             hold_w,
    input  logic             bubble_e,
    input  logic [31:0]      instruction_e,
    input  logic [XLEN-1:0]  pc_e,
    input  logic [XLEN-1:0]  alu_out_e,
    input  logic [XLEN-1:0]  wdata_e,
    input  logic             reg_wr_e,
    input  logic             rd_en_e,
    input  logic             wr_en_e,
    input  logic [1:0]       wb_sel_e,
    output logic [31:0]      instruction_w,
    output logic [XLEN-1:0]  pc_w,
    output logic [XLEN-1:0]  alu_out_w,
    output logic [XLEN-1:0]  wdata_w,
    output logic             reg_wr_w,
    output logic             rd_en_w,
    output logic             wr_en_w,
    output logic [1:0]       wb_sel_w,
    output logic             valid_w,
    output logic [CNT_W-1:0] instret
);

    logic [31:0]      insn_q, insn_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  alu_q, alu_d;
    logic [XLEN-1:0]  wdata_q, wdata_d;
    logic             reg_wr_q, reg_wr_d;
    logic             rd_en_q, rd_en_d;
    logic             wr_en_q, wr_en_d;
    logic [1:0]       wb_sel_q, wb_sel_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic retire;
    logic squash;
    logic load;

    // Retirement looks at what is in W before this edge; a stalled or
    // squashed W instruction does not count.
    assign retire = valid_q & ~hold_w & ~flush_w;
    // Flush beats hold, so a held store can still be killed by a trap.
    assign squash = flush_w | (~hold_w & bubble_e);
    assign load   = ~flush_w & ~hold_w & ~bubble_e;

    always_comb begin
        insn_d   = insn_q;
        pc_d     = pc_q;
        alu_d    = alu_q;
        wdata_d  = wdata_q;
        reg_wr_d = reg_wr_q;
        rd_en_d  = rd_en_q;
        wr_en_d  = wr_en_q;
        wb_sel_d = wb_sel_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q + (retire ? CNT_W'(1) : CNT_W'(0));

        if (squash) begin
            insn_d   = NOP_INSN;
            pc_d     = '0;
            alu_d    = '0;
            wdata_d  = '0;
            reg_wr_d = 1'b0;
            rd_en_d  = 1'b0;
            wr_en_d  = 1'b0;
            wb_sel_d = 2'b00;
            valid_d  = 1'b0;
        end else if (load) begin
            insn_d   = instruction_e;
            pc_d     = pc_e;
            alu_d    = alu_out_e;
            wdata_d  = wdata_e;
            // x0 is hard-wired; never advertise a write to it
            reg_wr_d = reg_wr_e & (instruction_e[11:7] != 5'd0);
            rd_en_d  = rd_en_e;
            wr_en_d  = wr_en_e;
            wb_sel_d = wb_sel_e;
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            insn_q   <= NOP_INSN;
            pc_q     <= '0;
            alu_q    <= '0;
            wdata_q  <= '0;
            reg_wr_q <= 1'b0;
            rd_en_q  <= 1'b0;
            wr_en_q  <= 1'b0;
            wb_sel_q <= 2'b00;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            insn_q   <= insn_d;
            pc_q     <= pc_d;
            alu_q    <= alu_d;
            wdata_q  <= wdata_d;
            reg_wr_q <= reg_wr_d;
            rd_en_q  <= rd_en_d;
            wr_en_q  <= wr_en_d;
            wb_sel_q <= wb_sel_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
        end
    end

    assign instruction_w = insn_q;
    assign pc_w          = pc_q;
    assign alu_out_w     = alu_q;
    assign wdata_w       = wdata_q;
    assign reg_wr_w      = reg_wr_q;
    assign rd_en_w       = rd_en_q;
    assign wr_en_w       = wr_en_q;
    assign wb_sel_w      = wb_sel_q;
    assign valid_w       = valid_q;
    assign instret       = cnt_q;

endmodule

// File: tb/tb_ew_pipeline_register.sv
// Bench for ew_pipeline_register: directed spec scenarios then random
// traffic against a behavioural model of the W stage.
module tb_ew_pipeline_register;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, flush_w, hold_w, bubble_e;
    logic [31:0] instruction_e, pc_e, alu_out_e, wdata_e;
    logic        reg_wr_e, rd_en_e, wr_en_e;
    logic [1:0]  wb_sel_e;

    logic [31:0] instruction_w, pc_w, alu_out_w, wdata_w;
    logic        reg_wr_w, rd_en_w, wr_en_w, valid_w;
    logic [1:0]  wb_sel_w;
    logic [63:0] instret;

    // small-counter copy used to exercise wrap-around quickly
    logic [31:0] s_insn, s_pc, s_alu, s_wd;
    logic        s_rw, s_rd, s_wr, s_valid;
    logic [1:0]  s_sel;
    logic [2:0]  s_cnt;

    ew_pipeline_register dut (
        .clk(clk), .rst_n(rst_n), .flush_w(flush_w), .hold_w(hold_w),
        .bubble_e(bubble_e), .instruction_e(instruction_e), .pc_e(pc_e),
        .alu_out_e(alu_out_e), .wdata_e(wdata_e), .reg_wr_e(reg_wr_e),
        .rd_en_e(rd_en_e), .wr_en_e(wr_en_e), .wb_sel_e(wb_sel_e),
        .instruction_w(instruction_w), .pc_w(pc_w), .alu_out_w(alu_out_w),
        .wdata_w(wdata_w), .reg_wr_w(reg_wr_w), .rd_en_w(rd_en_w),
        .wr_en_w(wr_en_w), .wb_sel_w(wb_sel_w), .valid_w(valid_w),
        .instret(instret)
    );

    ew_pipeline_register #(.CNT_W(3)) dut_s (
        .clk(clk), .rst_n(rst_n), .flush_w(flush_w), .hold_w(hold_w),
        .bubble_e(bubble_e), .instruction_e(instruction_e), .pc_e(pc_e),
        .alu_out_e(alu_out_e), .wdata_e(wdata_e), .reg_wr_e(reg_wr_e),
        .rd_en_e(rd_en_e), .wr_en_e(wr_en_e), .wb_sel_e(wb_sel_e),
        .instruction_w(s_insn), .pc_w(s_pc), .alu_out_w(s_alu),
        .wdata_w(s_wd), .reg_wr_w(s_rw), .rd_en_w(s_rd),
        .wr_en_w(s_wr), .wb_sel_w(s_sel), .valid_w(s_valid),
        .instret(s_cnt)
    );

    // reference model of what W should hold
    logic [31:0] m_insn, m_pc, m_alu, m_wd;
    logic        m_rw, m_rd, m_wr, m_valid;
    logic [1:0]  m_sel;
    longint unsigned m_cnt;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_bubble();
        m_insn = 32'h00000013; m_pc = 0; m_alu = 0; m_wd = 0;
        m_rw = 0; m_rd = 0; m_wr = 0; m_sel = 0; m_valid = 0;
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_bubble();
            m_cnt = 0;
        end else begin
            if (m_valid && !hold_w && !flush_w) m_cnt = m_cnt + 1;
            if (flush_w) model_bubble();
            else if (hold_w) ;
            else if (bubble_e) model_bubble();
            else begin
                m_insn = instruction_e; m_pc = pc_e; m_alu = alu_out_e;
                m_wd = wdata_e; m_rd = rd_en_e; m_wr = wr_en_e;
                m_sel = wb_sel_e; m_valid = 1;
                m_rw = reg_wr_e && (instruction_e[11:7] != 0);
            end
        end
    endtask

    task automatic check_all();
        chk("insn", 64'(instruction_w), 64'(m_insn));
        chk("pc", 64'(pc_w), 64'(m_pc));
        chk("alu", 64'(alu_out_w), 64'(m_alu));
        chk("wdata", 64'(wdata_w), 64'(m_wd));
        chk("reg_wr", 64'(reg_wr_w), 64'(m_rw));
        chk("rd_en", 64'(rd_en_w), 64'(m_rd));
        chk("wr_en", 64'(wr_en_w), 64'(m_wr));
        chk("wb_sel", 64'(wb_sel_w), 64'(m_sel));
        chk("valid", 64'(valid_w), 64'(m_valid));
        chk("instret", instret, m_cnt);
        chk("instret_small", 64'(s_cnt), m_cnt % 8);
    endtask

    task automatic set_e(input logic [31:0] insn, input logic [31:0] pc,
                         input logic rw, input logic rd, input logic wr,
                         input logic [1:0] sel);
        instruction_e = insn; pc_e = pc;
        alu_out_e = $urandom; wdata_e = $urandom;
        reg_wr_e = rw; rd_en_e = rd; wr_en_e = wr; wb_sel_e = sel;
    endtask

    task automatic step(input logic r, input logic f, input logic h,
                        input logic b);
        rst_n = r; flush_w = f; hold_w = h; bubble_e = b;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        model_bubble();
        m_cnt = 0;
        set_e(32'h0, 32'h0, 0, 0, 0, 0);

        // reset two cycles
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("rst_insn", 64'(instruction_w), 64'h13);
        chk("rst_instret", instret, 64'd0);

        // normal flow: addi x5,x0,7
        set_e(32'h00700293, 32'h100, 1, 0, 0, 2'b00);
        step(1, 0, 0, 0);
        chk("nf_insn", 64'(instruction_w), 64'h00700293);
        chk("nf_regwr", 64'(reg_wr_w), 64'd1);
        // x0 guard: addi x0,x1,1
        set_e(32'h00108013, 32'h104, 1, 0, 0, 2'b00);
        step(1, 0, 0, 0);
        chk("nf_instret", instret, 64'd1);
        chk("x0_regwr", 64'(reg_wr_w), 64'd0);
        chk("x0_valid", 64'(valid_w), 64'd1);

        // hold three cycles with changing E inputs
        for (int i = 0; i < 3; i++) begin
            set_e($urandom, $urandom, 1, 1, 1, 2'($urandom));
            step(1, 0, 1, 0);
            chk("hold_insn", 64'(instruction_w), 64'h00108013);
            chk("hold_instret", instret, 64'd1);
        end
        // release
        set_e(32'h00a00313, 32'h108, 1, 0, 0, 2'b00);
        step(1, 0, 0, 0);
        chk("rel_insn", 64'(instruction_w), 64'h00a00313);

        // bubble
        step(1, 0, 0, 1);
        chk("bub_valid", 64'(valid_w), 64'd0);

        // store held, then flushed
        set_e(32'h0062a023, 32'h10c, 0, 0, 1, 2'b00);
        step(1, 0, 0, 0);
        chk("st_wr", 64'(wr_en_w), 64'd1);
        step(1, 0, 1, 0);
        step(1, 1, 1, 0);
        chk("fl_wr", 64'(wr_en_w), 64'd0);
        chk("fl_instret", instret, 64'd3);

        // retire enough to wrap the 3-bit counter copy
        for (int i = 0; i < 10; i++) begin
            set_e(32'h00100093 | (32'(i) << 20), 32'(i * 4), 1, 0, 0, 0);
            step(1, 0, 0, 0);
        end
        chk("wrap_small", 64'(s_cnt), 64'((3 + 9) % 8));

        // reset in the middle of a hold
        step(0, 0, 1, 0);
        chk("rst_hold_cnt", instret, 64'd0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            set_e($urandom, $urandom, 1'($urandom), 1'($urandom),
                  1'($urandom), 2'($urandom));
            step(($urandom_range(0, 39) != 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
